// File: rtl/axi4_master_pkg.sv
// Shared types and constants for the AXI4 burst initiator.
package axi4_master_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_e;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 3'd3;

  // AxSIZE encoding for a full-width beat on a bus of the given bit width.
  function automatic logic [2:0] size_of(input int unsigned width);
    return 3'($clog2(width / 8));
  endfunction

endpackage

// File: rtl/axi4_if.sv
// Minimal AXI4 bus bundle: the five channels with the fields this initiator drives and samples.
interface axi4_if #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4
);
  logic [AXI_ID_WIDTH-1:0]       AWID;
  logic [AXI_ADDRESS_WIDTH-1:0]  AWADDR;
  logic [7:0]                    AWLEN;
  logic [2:0]                    AWSIZE;
  logic [1:0]                    AWBURST;
  logic                          AWVALID;
  logic                          AWREADY;

  logic [AXI_DATA_WIDTH-1:0]     WDATA;
  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB;
  logic                          WLAST;
  logic                          WVALID;
  logic                          WREADY;

  logic [AXI_ID_WIDTH-1:0]       BID;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;

  logic [AXI_ID_WIDTH-1:0]       ARID;
  logic [AXI_ADDRESS_WIDTH-1:0]  ARADDR;
  logic [7:0]                    ARLEN;
  logic [2:0]                    ARSIZE;
  logic [1:0]                    ARBURST;
  logic                          ARVALID;
  logic                          ARREADY;

  logic [AXI_ID_WIDTH-1:0]       RID;
  logic [AXI_DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                    RRESP;
  logic                          RLAST;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 initiator: one read or write burst at a time, data streamed
// through valid/ready ports, one completion pulse per command.
module axi4_burst_master
  import axi4_master_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [3:0]                   cmd_len,
  input  logic [1:0]                   cmd_burst,
  input  logic [AXI_ID_WIDTH-1:0]      cmd_id,
  input  logic                         wdat_valid,
  output logic                         wdat_ready,
  input  logic [AXI_DATA_WIDTH-1:0]    wdat_data,
  output logic                         rdat_valid,
  input  logic                         rdat_ready,
  output logic [AXI_DATA_WIDTH-1:0]    rdat_data,
  output logic                         rdat_last,
  output logic                         rsp_valid,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_err,
  axi4_if.master                       m
);

  localparam logic [2:0] BEAT_SIZE = size_of(AXI_DATA_WIDTH);

  state_e                       state_q, state_d;
  logic [AXI_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                   len_q, len_d;
  logic [1:0]                   burst_q, burst_d;
  logic [AXI_ID_WIDTH-1:0]      id_q, id_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [1:0]                   resp_q, resp_d;
  logic                         err_q, err_d;
  // Held low for the first cycle after reset so cmd_ready reads 0 while ARESETn is asserted.
  logic                         live_q;

  logic aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic last_beat;

  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      resp_q  <= OKAY;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    wdat_ready = 1'b0;
    rdat_valid = 1'b0;
    rdat_data  = '0;
    rdat_last  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_resp   = OKAY;
    rsp_err    = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    w_data     = '0;
    w_last     = 1'b0;
    b_ready    = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = live_q;
        if (live_q && cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          burst_d = cmd_burst;
          id_d    = cmd_id;
          cnt_d   = '0;
          resp_d  = OKAY;
          // An illegal WRAP length is flagged up front; the burst still goes out as given.
          err_d   = (cmd_burst == WRAP) && !(cmd_len inside {4'd1, 4'd3, 4'd7, 4'd15});
          state_d = cmd_write ? AW : AR;
        end
      end
      AW: begin
        aw_valid = 1'b1;
        if (m.AWREADY) state_d = W;
      end
      W: begin
        w_valid    = wdat_valid;
        wdat_ready = m.WREADY;
        w_data     = wdat_data;
        w_last     = last_beat;
        if (wdat_valid && m.WREADY) begin
          cnt_d = cnt_q + 4'd1;
          if (last_beat) state_d = B;
        end
      end
      B: begin
        b_ready = 1'b1;
        if (m.BVALID) begin
          resp_d = m.BRESP;
          if (m.BID != id_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
      AR: begin
        ar_valid = 1'b1;
        if (m.ARREADY) state_d = R;
      end
      R: begin
        r_ready    = rdat_ready;
        rdat_valid = m.RVALID;
        rdat_data  = m.RDATA;
        rdat_last  = m.RLAST;
        if (m.RVALID && rdat_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (m.RRESP > resp_d) resp_d = m.RRESP;
          if ((m.RID != id_q) || (m.RLAST != last_beat)) err_d = 1'b1;
          // A responder that ends early also ends the transaction.
          if (last_beat || m.RLAST) state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_resp  = resp_q;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m.AWID    = id_q;
  assign m.AWADDR  = addr_q;
  assign m.AWLEN   = {4'd0, len_q};
  assign m.AWSIZE  = aw_valid ? BEAT_SIZE : 3'd0;
  assign m.AWBURST = burst_q;
  assign m.AWVALID = aw_valid;

  assign m.WDATA   = w_data;
  assign m.WSTRB   = (state_q == W) ? '1 : '0;
  assign m.WLAST   = w_last;
  assign m.WVALID  = w_valid;

  assign m.BREADY  = b_ready;

  assign m.ARID    = id_q;
  assign m.ARADDR  = addr_q;
  assign m.ARLEN   = {4'd0, len_q};
  assign m.ARSIZE  = ar_valid ? BEAT_SIZE : 3'd0;
  assign m.ARBURST = burst_q;
  assign m.ARVALID = ar_valid;

  assign m.RREADY  = r_ready;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: a small SRAM responder with fault knobs,
// a table of burst vectors, and hand sequences for error and reset corner cases.
module tb_axi4_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [1:0]  cmd_burst = '0;
  logic [3:0]  cmd_id = '0;
  logic        wdat_valid = 1'b0, wdat_ready;
  logic [31:0] wdat_data = '0;
  logic        rdat_valid, rdat_ready = 1'b0, rdat_last;
  logic [31:0] rdat_data;
  logic        rsp_valid, rsp_err;
  logic [1:0]  rsp_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axi4_if #(.AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();

  axi4_burst_master #(.AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data), .rdat_last(rdat_last),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .m(bus)
  );

  // ---------------- SRAM responder ----------------
  logic [31:0] mem [0:255];
  bit          mem_inited;
  logic        w_act = 1'b0, b_pend = 1'b0, r_act = 1'b0;
  logic [31:0] wa, ra;
  logic [7:0]  wl, rl, wb, rb;
  logic [1:0]  wbu, rbu;
  logic [3:0]  wid, rid;
  int          fault_beat = -1;
  int          early_beat = -1;
  logic [1:0]  bresp_k = 2'd0;
  logic        bid_flip = 1'b0;
  logic [7:0]  cap_awlen, cap_arlen;
  logic [1:0]  cap_awburst, cap_arburst;
  logic [2:0]  cap_awsize;
  logic [31:0] cap_awaddr;
  logic [15:0] wlast_log;
  int          wbeats_seen;

  function automatic logic [31:0] nxt(logic [31:0] a, logic [7:0] len, logic [1:0] bu);
    logic [31:0] bnd;
    if (bu == 2'd0) return a;
    if (bu == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      bnd = (32'(len) + 32'd1) * 32'd4;
      return (a & ~(bnd - 32'd1)) | ((a + 32'd4) & (bnd - 32'd1));
    end
    return a + 32'd4;
  endfunction

  assign bus.AWREADY = ARESETn && !w_act && !b_pend;
  assign bus.WREADY  = w_act;
  assign bus.BVALID  = b_pend;
  assign bus.BRESP   = bresp_k;
  assign bus.BID     = wid ^ {3'b000, bid_flip};
  assign bus.ARREADY = ARESETn && !r_act;
  assign bus.RVALID  = r_act;
  assign bus.RDATA   = mem[ra[9:2]];
  assign bus.RRESP   = (int'(rb) == fault_beat) ? 2'd2 : 2'd0;
  assign bus.RID     = (int'(rb) == fault_beat) ? (rid ^ 4'h1) : rid;
  assign bus.RLAST   = (rb == rl) || (int'(rb) == early_beat);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_act  <= 1'b0;
      b_pend <= 1'b0;
      r_act  <= 1'b0;
      if (!mem_inited) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i * 4);
        mem_inited <= 1'b1;
      end
    end else begin
      if (bus.AWVALID && bus.AWREADY) begin
        wa <= bus.AWADDR; wl <= bus.AWLEN; wbu <= bus.AWBURST; wid <= bus.AWID;
        wb <= 8'd0; w_act <= 1'b1;
        cap_awlen <= bus.AWLEN; cap_awburst <= bus.AWBURST;
        cap_awsize <= bus.AWSIZE; cap_awaddr <= bus.AWADDR;
        wlast_log <= '0; wbeats_seen <= 0;
      end
      if (bus.WVALID && bus.WREADY) begin
        mem[wa[9:2]] <= bus.WDATA;
        wa <= nxt(wa, wl, wbu);
        wb <= wb + 8'd1;
        wlast_log[wb[3:0]] <= bus.WLAST;
        wbeats_seen <= wbeats_seen + 1;
        if (wb == wl) begin
          w_act  <= 1'b0;
          b_pend <= 1'b1;
        end
      end
      if (bus.BVALID && bus.BREADY) b_pend <= 1'b0;
      if (bus.ARVALID && bus.ARREADY) begin
        ra <= bus.ARADDR; rl <= bus.ARLEN; rbu <= bus.ARBURST; rid <= bus.ARID;
        rb <= 8'd0; r_act <= 1'b1;
        cap_arlen <= bus.ARLEN; cap_arburst <= bus.ARBURST;
      end
      if (bus.RVALID && bus.RREADY) begin
        ra <= nxt(ra, rl, rbu);
        rb <= rb + 8'd1;
        if (bus.RLAST) r_act <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [3:0] id, input logic [31:0] seed,
                         input int wdelay, input logic [31:0] rmask,
                         output logic [15:0][31:0] rd, output int nb, output int last_at,
                         output logic [1:0] resp, output logic err, output bit done);
    rd = '0; nb = 0; last_at = -1; resp = 2'd0; err = 1'b0; done = 1'b0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    cmd_burst = burst; cmd_id = id;
    for (int c = 0; c < 50 && !cmd_ready; c++) @(negedge ACLK);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      wdat_valid = wr && (cyc >= wdelay) && (nb <= int'(len));
      wdat_data  = seed + 32'(nb) * 32'h11;
      rdat_ready = rmask[cyc % 32];
      #1;
      if (wdat_valid && wdat_ready) nb++;
      if (rdat_valid && rdat_ready) begin
        if (nb < 16) rd[nb] = rdat_data;
        if (rdat_last && last_at < 0) last_at = nb;
        nb++;
      end
      if (rsp_valid) begin
        resp = rsp_resp;
        err  = rsp_err;
        done = 1'b1;
      end
      @(negedge ACLK);
    end
    wdat_valid = 1'b0;
    rdat_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               wr;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [31:0]      seed;
    int               wdelay;
    logic [31:0]      rmask;
    logic [15:0][31:0] exp_rd;
    int               exp_nb;
    logic [1:0]       exp_resp;
    logic             exp_err;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [3:0] len, logic [1:0] burst,
                              logic [3:0] id, logic [31:0] seed, int wdelay,
                              logic [31:0] rmask, logic err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.id = id; v.seed = seed;
    v.wdelay = wdelay; v.rmask = rmask; v.exp_rd = '0; v.exp_nb = int'(len) + 1;
    v.exp_resp = 2'd0; v.exp_err = err;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  logic [15:0][31:0] rd;
  int                nb, last_at;
  logic [1:0]        resp;
  logic              err;
  bit                done;

  initial begin
    vecs[0]  = mk(1, 32'h100, 4'd3,  2'd1, 4'd1,  32'h11,   0, '1, 1'b0);
    vecs[1]  = mk(0, 32'h100, 4'd3,  2'd1, 4'd2,  32'h0,    0, '1, 1'b0);
    vecs[1].exp_rd[0] = 32'h11; vecs[1].exp_rd[1] = 32'h22;
    vecs[1].exp_rd[2] = 32'h33; vecs[1].exp_rd[3] = 32'h44;
    vecs[2]  = mk(0, 32'h108, 4'd3,  2'd2, 4'd3,  32'h0,    0, '1, 1'b0);
    vecs[2].exp_rd[0] = 32'h33; vecs[2].exp_rd[1] = 32'h44;
    vecs[2].exp_rd[2] = 32'h11; vecs[2].exp_rd[3] = 32'h22;
    vecs[3]  = mk(1, 32'h140, 4'd0,  2'd1, 4'd4,  32'h55,   5, '1, 1'b0);
    vecs[4]  = mk(0, 32'h140, 4'd1,  2'd1, 4'd5,  32'h0,    0, 32'h5555_5555, 1'b0);
    vecs[4].exp_rd[0] = 32'h55; vecs[4].exp_rd[1] = 32'hA000_0144;
    vecs[5]  = mk(0, 32'h104, 4'd2,  2'd0, 4'd6,  32'h0,    0, '1, 1'b0);
    vecs[5].exp_rd[0] = 32'h22; vecs[5].exp_rd[1] = 32'h22; vecs[5].exp_rd[2] = 32'h22;
    vecs[6]  = mk(0, 32'h100, 4'd2,  2'd2, 4'd7,  32'h0,    0, '1, 1'b1);
    vecs[6].exp_rd[0] = 32'h11; vecs[6].exp_rd[1] = 32'h22; vecs[6].exp_rd[2] = 32'h33;
    vecs[7]  = mk(1, 32'h200, 4'd15, 2'd1, 4'd8,  32'h1000, 0, '1, 1'b0);
    vecs[8]  = mk(0, 32'h200, 4'd15, 2'd1, 4'd9,  32'h0,    0, '1, 1'b0);
    for (int i = 0; i < 16; i++) vecs[8].exp_rd[i] = 32'h1000 + 32'(i) * 32'h11;
    vecs[9]  = mk(1, 32'h188, 4'd3,  2'd2, 4'd10, 32'h70,   0, '1, 1'b0);
    vecs[10] = mk(0, 32'h180, 4'd3,  2'd1, 4'd11, 32'h0,    0, '1, 1'b0);
    vecs[10].exp_rd[0] = 32'h92; vecs[10].exp_rd[1] = 32'hA3;
    vecs[10].exp_rd[2] = 32'h70; vecs[10].exp_rd[3] = 32'h81;

    // Reset state
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst AWVALID",   32'(bus.AWVALID), 32'd0);
    chk("rst WVALID",    32'(bus.WVALID), 32'd0);
    chk("rst WLAST",     32'(bus.WLAST), 32'd0);
    chk("rst BREADY",    32'(bus.BREADY), 32'd0);
    chk("rst ARVALID",   32'(bus.ARVALID), 32'd0);
    chk("rst RREADY",    32'(bus.RREADY), 32'd0);
    chk("rst rsp",       {29'd0, rsp_valid, rsp_resp}, 32'd0);
    chk("rst rdat",      {30'd0, rdat_valid, rdat_last}, 32'd0);
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

    for (int k = 0; k < NV; k++) begin
      run_txn(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].burst, vecs[k].id, vecs[k].seed,
              vecs[k].wdelay, vecs[k].rmask, rd, nb, last_at, resp, err, done);
      $display("[TB] txn %0d %s addr=%h len=%0d burst=%0d beats=%0d resp=%0d err=%0b",
               k, vecs[k].wr ? "WR" : "RD", vecs[k].addr, vecs[k].len, vecs[k].burst,
               nb, resp, err);
      chk($sformatf("v%0d done", k),  32'(done), 32'd1);
      chk($sformatf("v%0d beats", k), 32'(nb), 32'(vecs[k].exp_nb));
      chk($sformatf("v%0d resp", k),  32'(resp), 32'(vecs[k].exp_resp));
      chk($sformatf("v%0d err", k),   32'(err), 32'(vecs[k].exp_err));
      if (vecs[k].wr) begin
        chk($sformatf("v%0d AWLEN", k),   32'(cap_awlen), 32'(vecs[k].len));
        chk($sformatf("v%0d AWBURST", k), 32'(cap_awburst), 32'(vecs[k].burst));
        chk($sformatf("v%0d AWSIZE", k),  32'(cap_awsize), 32'd2);
        chk($sformatf("v%0d AWADDR", k),  cap_awaddr, vecs[k].addr);
        chk($sformatf("v%0d WLAST map", k), 32'(wlast_log), 32'(16'd1 << vecs[k].len));
        chk($sformatf("v%0d W beats", k), 32'(wbeats_seen), 32'(vecs[k].exp_nb));
      end else begin
        chk($sformatf("v%0d ARLEN", k),   32'(cap_arlen), 32'(vecs[k].len));
        chk($sformatf("v%0d ARBURST", k), 32'(cap_arburst), 32'(vecs[k].burst));
        chk($sformatf("v%0d last_at", k), 32'(last_at), 32'(vecs[k].len));
        for (int i = 0; i < vecs[k].exp_nb; i++)
          chk($sformatf("v%0d rdat[%0d]", k, i), rd[i], vecs[k].exp_rd[i]);
      end
    end

    // Wrong RID plus SLVERR on beat 2 of 3
    fault_beat = 1;
    run_txn(0, 32'h100, 4'd2, 2'd1, 4'd6, 32'h0, 0, '1, rd, nb, last_at, resp, err, done);
    fault_beat = -1;
    $display("[TB] txn rid-fault beats=%0d resp=%0d err=%0b", nb, resp, err);
    chk("ridf done", 32'(done), 32'd1);
    chk("ridf resp", 32'(resp), 32'd2);
    chk("ridf err",  32'(err), 32'd1);
    chk("ridf rdat[1]", rd[1], 32'h22);
    chk("ridf rdat[2]", rd[2], 32'h33);

    // DECERR and wrong BID on a write response
    bresp_k = 2'd3; bid_flip = 1'b1;
    run_txn(1, 32'h1F0, 4'd0, 2'd1, 4'd3, 32'h99, 0, '1, rd, nb, last_at, resp, err, done);
    bresp_k = 2'd0; bid_flip = 1'b0;
    $display("[TB] txn bresp-fault beats=%0d resp=%0d err=%0b", nb, resp, err);
    chk("bf done", 32'(done), 32'd1);
    chk("bf resp", 32'(resp), 32'd3);
    chk("bf err",  32'(err), 32'd1);

    // Responder asserts RLAST on beat 2 of a 4-beat read
    early_beat = 1;
    run_txn(0, 32'h100, 4'd3, 2'd1, 4'd2, 32'h0, 0, '1, rd, nb, last_at, resp, err, done);
    early_beat = -1;
    $display("[TB] txn early-rlast beats=%0d resp=%0d err=%0b", nb, resp, err);
    chk("el done",    32'(done), 32'd1);
    chk("el beats",   32'(nb), 32'd2);
    chk("el last_at", 32'(last_at), 32'd1);
    chk("el err",     32'(err), 32'd1);

    // Reset during beat 2 of a 4-beat write
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = 4'd3;
    cmd_burst = 2'd1; cmd_id = 4'd12;
    for (int c = 0; c < 50 && !cmd_ready; c++) @(negedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    wdat_valid = 1'b1; wdat_data = 32'hB0;
    #1;
    for (int c = 0; c < 50 && !wdat_ready; c++) begin
      @(negedge ACLK);
      #1;
    end
    chk("rstb beat1 ready", 32'(wdat_ready), 32'd1);
    @(negedge ACLK);
    wdat_data = 32'hB1;
    #1;
    chk("rstb beat2 WVALID", 32'(bus.WVALID), 32'd1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    #1;
    chk("rstb WVALID",    32'(bus.WVALID), 32'd0);
    chk("rstb AWVALID",   32'(bus.AWVALID), 32'd0);
    chk("rstb cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rstb rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge ACLK);
    #1;
    chk("rstb rsp_valid2", 32'(rsp_valid), 32'd0);
    ARESETn = 1'b1;
    wdat_valid = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    chk("rstb cmd_ready after", 32'(cmd_ready), 32'd1);
    $display("[TB] txn reset-mid-burst");
    run_txn(1, 32'h300, 4'd1, 2'd1, 4'd13, 32'hC0, 0, '1, rd, nb, last_at, resp, err, done);
    $display("[TB] txn post-reset write beats=%0d resp=%0d err=%0b", nb, resp, err);
    chk("prw done", 32'(done), 32'd1);
    chk("prw beats", 32'(nb), 32'd2);
    chk("prw resp_err", {29'd0, resp, err}, 32'd0);
    run_txn(0, 32'h300, 4'd1, 2'd1, 4'd14, 32'h0, 0, '1, rd, nb, last_at, resp, err, done);
    $display("[TB] txn post-reset read beats=%0d resp=%0d err=%0b", nb, resp, err);
    chk("prr rdat[0]", rd[0], 32'hC0);
    chk("prr rdat[1]", rd[1], 32'hD1);
    chk("prr err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
